// File: rtl/rev_gpio_arb_pkg.sv
// ---------------------------------------------------------------------------
// rev_gpio_arb_pkg
// Shared types and defaults for the round-robin APB arbiter that fronts the
// GPIO peripheral.
//   arb_state_e : arbiter FSM states (IDLE, SETUP, ACCESS)
//   apb_cmd_t   : one captured requester command (write, addr, wdata, strb)
//   make_cmd    : builds a command, zeroing data and strobes for reads
// ---------------------------------------------------------------------------
package rev_gpio_arb_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_STRB_W = DEFAULT_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                      write;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
        logic [DEFAULT_STRB_W-1:0] strb;
    } apb_cmd_t;

    // Reads must present zero write data and zero strobes on the bus, so the
    // command is sanitised once at capture time rather than on every cycle.
    function automatic apb_cmd_t make_cmd(
        input logic                      write,
        input logic [DEFAULT_ADDR_W-1:0] addr,
        input logic [DEFAULT_DATA_W-1:0] wdata,
        input logic [DEFAULT_STRB_W-1:0] strb
    );
        apb_cmd_t cmd;
        cmd.write = write;
        cmd.addr  = addr;
        cmd.wdata = write ? wdata : '0;
        cmd.strb  = write ? strb  : '0;
        return cmd;
    endfunction

endpackage

// File: rtl/rev_rr_arb.sv
// ---------------------------------------------------------------------------
// rev_rr_arb
// Purely combinational round-robin selector. Searches upward from the slot
// after ptr, wrapping, and picks the first active request.
//   req       : request vector
//   ptr       : index of the most recently served requester
//   grant     : one-hot grant (zero when nothing requests)
//   grant_idx : binary index of the granted requester
//   any       : at least one request is active
// ---------------------------------------------------------------------------
module rev_rr_arb #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Walk the N candidates starting just after ptr; the first hit wins, so
    // the last-served requester naturally becomes lowest priority.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rev_gpio_apb_arb.sv
// ---------------------------------------------------------------------------
// rev_gpio_apb_arb
// Round-robin APB master that shares one GPIO APB slave between NUM_REQ
// requesters. Each accepted command becomes one SETUP/ACCESS sequence and
// produces exactly one response pulse back to its owner.
//   pclk, prst              : clock, synchronous active-high reset
//   req_valid/write/addr/
//   wdata/strb              : flattened per-requester command inputs
//   req_ready               : combinational accept (one-hot or zero, IDLE only)
//   rsp_valid               : one-cycle response pulse to the owner
//   rsp_rdata, rsp_err      : shared response payload, qualified by rsp_valid
//   psel/penable/pwrite/
//   paddr/pwdata/pstrb      : APB master outputs
//   pready/pslverr/prdata   : APB slave status and read data
// ---------------------------------------------------------------------------
module rev_gpio_apb_arb
    import rev_gpio_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int WAIT_MAX = 15
) (
    input  logic                          pclk,
    input  logic                          prst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_W-1:0]             paddr,
    output logic [DATA_W-1:0]             pwdata,
    output logic [DATA_W/8-1:0]           pstrb,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_W-1:0]             prdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(WAIT_MAX + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_e           state;
    apb_cmd_t             cmd;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [CNT_W-1:0]     wait_cnt;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    logic                 win_write;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic [STRB_W-1:0]    win_strb;

    rev_rr_arb #(
        .N (NUM_REQ)
    ) u_rr_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Pick the winning requester's payload out of the flattened buses.
    always_comb begin
        win_write = req_write[arb_idx];
        win_addr  = req_addr[arb_idx*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[arb_idx*DATA_W +: DATA_W];
        win_strb  = req_strb[arb_idx*STRB_W +: STRB_W];
    end

    // Accept only in IDLE; held low during reset so nothing is taken then.
    assign req_ready = (state == IDLE && !prst) ? arb_grant : '0;

    // The bus payload comes straight from the command register, so it holds
    // its last value while psel is low.
    assign pwrite = cmd.write;
    assign paddr  = cmd.addr;
    assign pwdata = cmd.wdata;
    assign pstrb  = cmd.strb;

    // Main FSM. psel/penable and the response are registered here. A
    // transfer finishes on pready, or on the ACCESS cycle after WAIT_MAX
    // low-pready cycles have been counted (so ACCESS lasts WAIT_MAX+1 cycles).
    always_ff @(posedge pclk) begin
        if (prst) begin
            state     <= IDLE;
            cmd       <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            owner     <= '0;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        cmd      <= make_cmd(win_write, win_addr, win_wdata, win_strb);
                        owner    <= arb_idx;
                        wait_cnt <= '0;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= ONE_HOT0 << owner;
                        rsp_rdata <= cmd.write ? '0 : prdata;
                        rsp_err   <= pslverr;
                        ptr       <= owner;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                        rsp_valid <= ONE_HOT0 << owner;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        ptr       <= owner;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rev_gpio_apb_arb.sv
// ---------------------------------------------------------------------------
// tb_rev_gpio_apb_arb
// Directed bench for rev_gpio_apb_arb with two requesters and a scripted APB
// slave (pready/pslverr/prdata driven by the bench).
// ---------------------------------------------------------------------------
module tb_rev_gpio_apb_arb;

    logic        pclk = 1'b0;
    logic        prst;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int errors = 0;
    int checks = 0;

    rev_gpio_apb_arb #(
        .NUM_REQ  (2),
        .ADDR_W   (4),
        .DATA_W   (32),
        .WAIT_MAX (15)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    // 100 MHz-style free-running clock.
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic write,
                                 input logic [3:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb);
        req_valid[idx]          = valid;
        req_write[idx]          = write;
        req_addr[idx*4 +: 4]    = addr;
        req_wdata[idx*32 +: 32] = wdata;
        req_strb[idx*4 +: 4]    = strb;
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Bus snapshot: {psel, penable, pwrite, paddr, pstrb, pwdata}.
    function automatic logic [42:0] apbBus();
        return {psel, penable, pwrite, paddr, pstrb, pwdata};
    endfunction

    initial begin
        logic [1:0] expg;
        prst      = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;

        // Reset state
        step();
        step();
        checkOutput("reset_bus", 64'(apbBus()), 64'd0);
        checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        checkOutput("reset_ready", 64'(req_ready), 64'd0);
        prst = 1'b0;

        // Single write from requester 0, zero wait states
        applyStimulus(0, 1'b1, 1'b1, 4'h1, 32'h0000_00FF, 4'hF);
        pready = 1'b1;
        #1;
        checkOutput("wr_ready", 64'(req_ready), 64'(2'b01));
        step();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        checkOutput("wr_setup", 64'(apbBus()), 64'({1'b1, 1'b0, 1'b1, 4'h1, 4'hF, 32'h0000_00FF}));
        step();
        checkOutput("wr_access", 64'(apbBus()), 64'({1'b1, 1'b1, 1'b1, 4'h1, 4'hF, 32'h0000_00FF}));
        checkOutput("wr_no_early_rsp", 64'(rsp_valid), 64'd0);
        step();
        checkOutput("wr_rsp", {rsp_valid, rsp_err}, 64'({2'b01, 1'b0}));
        checkOutput("wr_idle_hold", 64'(apbBus()), 64'({1'b0, 1'b0, 1'b1, 4'h1, 4'hF, 32'h0000_00FF}));

        // Read from requester 1 with 4 wait states, accepted in the response cycle
        applyStimulus(1, 1'b1, 1'b0, 4'h3, 32'h1234_5678, 4'hF);
        pready = 1'b0;
        prdata = 32'hA5A5_0001;
        #1;
        checkOutput("rd_ready", 64'(req_ready), 64'(2'b10));
        step();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        checkOutput("rd_setup", 64'(apbBus()), 64'({1'b1, 1'b0, 1'b0, 4'h3, 4'h0, 32'h0}));
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) pready = 1'b1;
            checkOutput("rd_access", 64'(apbBus()), 64'({1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0}));
            checkOutput("rd_wait_rsp", 64'(rsp_valid), 64'd0);
        end
        step();
        checkOutput("rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'({2'b10, 1'b0, 32'hA5A5_0001}));

        // Contention after reset: strict alternation starting at requester 0
        prst = 1'b1;
        step();
        prst = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 4'h2, 32'h0000_0011, 4'h3);
        applyStimulus(1, 1'b1, 1'b0, 4'h5, 32'h0000_0022, 4'hF);
        pready = 1'b1;
        prdata = 32'hC0DE_0000;
        expg   = 2'b01;
        for (int t = 0; t < 6; t++) begin
            #1;
            checkOutput("rr_grant", 64'(req_ready), 64'(expg));
            step();
            checkOutput("rr_setup", 64'(apbBus()),
                        (expg == 2'b01) ? 64'({1'b1, 1'b0, 1'b1, 4'h2, 4'h3, 32'h0000_0011})
                                        : 64'({1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 32'h0}));
            step();
            step();
            checkOutput("rr_rsp", {rsp_valid, rsp_rdata},
                        (expg == 2'b01) ? 64'({2'b01, 32'h0}) : 64'({2'b10, 32'hC0DE_0000}));
            expg = ~expg;
        end
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

        // Timeout: pready never rises, ACCESS lasts WAIT_MAX+1 = 16 cycles
        applyStimulus(0, 1'b1, 1'b0, 4'h4, 32'h0, 4'h0);
        pready = 1'b0;
        prdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("to_ready", 64'(req_ready), 64'(2'b01));
        step();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            step();
            checkOutput("to_access", 64'({psel, penable, rsp_valid}), 64'(4'b1100));
        end
        step();
        checkOutput("to_rsp", {rsp_valid, rsp_err, psel, penable, rsp_rdata},
                    64'({2'b01, 1'b1, 1'b0, 1'b0, 32'h0}));

        // Slave error on a write to 0x7 from requester 1
        applyStimulus(1, 1'b1, 1'b1, 4'h7, 32'h0000_0008, 4'h1);
        pready  = 1'b1;
        pslverr = 1'b1;
        #1;
        checkOutput("se_ready", 64'(req_ready), 64'(2'b10));
        step();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        checkOutput("se_setup", 64'(apbBus()), 64'({1'b1, 1'b0, 1'b1, 4'h7, 4'h1, 32'h0000_0008}));
        step();
        step();
        checkOutput("se_rsp", {rsp_valid, rsp_err}, 64'({2'b10, 1'b1}));
        pslverr = 1'b0;

        // Unmapped address 0xF from requester 0 is forwarded and answered verbatim
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0, 4'h0);
        prdata = 32'h0000_1234;
        #1;
        checkOutput("um_ready", 64'(req_ready), 64'(2'b01));
        step();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        checkOutput("um_setup", 64'(apbBus()), 64'({1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0}));
        step();
        step();
        checkOutput("um_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'({2'b01, 1'b0, 32'h0000_1234}));

        // Reset during the 2nd ACCESS wait cycle of a requester 1 read
        applyStimulus(1, 1'b1, 1'b0, 4'h2, 32'h0, 4'h0);
        pready = 1'b0;
        #1;
        checkOutput("mr_ready", 64'(req_ready), 64'(2'b10));
        step();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        step();
        step();
        checkOutput("mr_access2", 64'({psel, penable}), 64'(2'b11));
        prst = 1'b1;
        step();
        checkOutput("mr_after_rst", 64'({psel, penable, rsp_valid}), 64'd0);
        prst = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 4'h6, 32'h0000_0066, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 4'h9, 32'h0000_0099, 4'hF);
        pready = 1'b1;
        #1;
        checkOutput("mr_grant0", 64'(req_ready), 64'(2'b01));
        step();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        checkOutput("mr_setup", 64'(apbBus()), 64'({1'b1, 1'b0, 1'b1, 4'h6, 4'hF, 32'h0000_0066}));
        step();
        step();
        checkOutput("mr_rsp", {rsp_valid, rsp_err}, 64'({2'b01, 1'b0}));
        step();
        checkOutput("mr_pulse_end", 64'(rsp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
